// File: rtl/button_input_unit.sv
// -----------------------------------------------------------------------------
// button_input_unit
//
// Serves the processor's IN instruction. The CPU raises in_req and stalls until
// a debounced button press is seen; the synchronised switch value is then
// returned in in_data together with a one-cycle in_ack.
//
// Optional feature macro: BUTTON_FIFO_EN
//   undefined (default): only a press seen while a request is waiting is
//                        captured; presses at any other time are discarded and
//                        overflow is tied to 0.
//   defined            : every press (in any state) queues the switch value in
//                        a FIFO_DEPTH-entry FIFO; a waiting request pops the
//                        head. A press against a full FIFO is dropped and sets
//                        the sticky overflow flag.
//
// Parameters
//   DATA_W      width of the switch bank and of in_data
//   FIFO_DEPTH  press-buffer entries (power of two, >= 2); BUTTON_FIFO_EN only
//
// Ports
//   clk           system clock, all logic on its rising edge
//   reset_n       synchronous active-low reset
//   button_pulse  debounced press pulse, high for one or more cycles per press
//   switches      raw asynchronous switch inputs
//   in_req        CPU executing IN; held until in_ack, then dropped
//   in_data       captured switch value (registered, holds until next capture)
//   in_ack        one-cycle acknowledge, in_data valid in the same cycle
//   stall         in_req && !in_ack, combinational PC/pipeline hold
//   waiting       registered, high while a request waits for a press
//   overflow      sticky dropped-press flag (0 without BUTTON_FIFO_EN)
// -----------------------------------------------------------------------------
module button_input_unit #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              button_pulse,
  input  logic [DATA_W-1:0] switches,
  input  logic              in_req,
  output logic [DATA_W-1:0] in_data,
  output logic              in_ack,
  output logic              stall,
  output logic              waiting,
  output logic              overflow
);

  // Reject a buffer depth the wrapping pointers cannot handle.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sw_meta_q, sw_sync_q;
  logic                pulse_dly_q;
  logic [DATA_W-1:0]   in_data_q, in_data_d;
  logic                ack_q, ack_d;
  logic                waiting_q, waiting_d;

  logic                press;
  logic                capture_ok;   // data available for a waiting request
  logic [DATA_W-1:0]   capture_val;  // value loaded into in_data on capture
  logic                capture;      // WAIT -> ACK transition this cycle

  // Rising edge of the debounced pulse: a long pulse counts as one press.
  assign press   = button_pulse && !pulse_dly_q;

  // Abort (in_req dropped) takes priority over a coincident capture.
  assign capture = (state_q == S_WAIT) && in_req && capture_ok;

  // Input conditioning: switch synchroniser and pulse delay.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      pulse_dly_q <= 1'b0;
    end else begin
      sw_meta_q   <= switches;
      sw_sync_q   <= sw_meta_q;
      pulse_dly_q <= button_pulse;
    end
  end

`ifdef BUTTON_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              fifo_full;
  logic              push;
  logic              pop;

  assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign push        = press && !fifo_full;
  assign pop         = capture;
  assign capture_ok  = (count_q != '0);
  assign capture_val = fifo_mem[rd_ptr_q];

  // Pointers are exactly log2(depth) wide, so they wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q || (press && fifo_full);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage holds data only; emptiness is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= sw_sync_q;
  end

  assign overflow = ovf_q;
`else
  assign capture_ok  = press;
  assign capture_val = sw_sync_q;
  assign overflow    = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state. RELEASE blocks a held request from taking a second press.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (in_req) state_d = S_WAIT;
      S_WAIT: begin
        if (!in_req)      state_d = S_IDLE;
        else if (capture) state_d = S_ACK;
      end
      S_ACK:     state_d = S_RELEASE;
      S_RELEASE: if (!in_req) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs, computed one cycle ahead so they leave the block registered.
  always_comb begin
    ack_d     = (state_d == S_ACK);
    waiting_d = (state_d == S_WAIT);
    in_data_d = capture ? capture_val : in_data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_data_q <= '0;
      ack_q     <= 1'b0;
      waiting_q <= 1'b0;
    end else begin
      in_data_q <= in_data_d;
      ack_q     <= ack_d;
      waiting_q <= waiting_d;
    end
  end

  assign in_data = in_data_q;
  assign in_ack  = ack_q;
  assign waiting = waiting_q;
  assign stall   = in_req && !ack_q;

endmodule
